// File: rtl/rr_grant_xfer.sv
// Grant consumer for a 4-way round-robin arbiter: qualifies the one-hot
// grant against the live requests, streams the winner's burst onto a
// valid/ready bus, then acks the arbiter and waits for its token to move.
module rr_grant_xfer #(
    parameter int DW      = 8,
    parameter int LW      = 4,
    parameter int HOLDOFF = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [3:0]      grant,
    input  logic [4*LW-1:0] len,
    input  logic [4*DW-1:0] data,
    output logic [3:0]      rd,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic [1:0]      m_src,
    output logic            m_last,
    output logic            ack,
    output logic            busy,
    output logic            err_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Wide enough to hold HOLDOFF-1.
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t        state, state_n;
    logic [1:0]    src;
    logic [LW-1:0] cnt;
    logic [HW-1:0] hold;

    logic [3:0]    g;
    logic          g_multi;
    logic [1:0]    g_idx;
    logic          last_beat;

    assign g         = grant & req;
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign g_multi   = (g & (g - 4'd1)) != 4'd0;
    assign last_beat = (cnt == '0);

    // Index of the qualified grant bit (only used when g is one-hot).
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        g_idx = 2'd0;
        case (g)
            4'b0010: g_idx = 2'd1;
            4'b0100: g_idx = 2'd2;
            4'b1000: g_idx = 2'd3;
            default: g_idx = 2'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and output decode; ack, busy and m_valid depend on the registered state only.
    always_comb begin
        state_n = state;
        m_valid = 1'b0;
        m_src   = 2'd0;
        m_data  = '0;
        m_last  = 1'b0;
        rd      = 4'd0;
        ack     = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req != 4'd0) begin
                    if (g == 4'd0)    state_n = ACK;   // token on an idle slot: skip it
                    else if (!g_multi) state_n = XFER;
                end
            end
            XFER: begin
                m_valid = 1'b1;
                m_src   = src;
                m_data  = data[int'(src)*DW +: DW];
                m_last  = last_beat;
                if (m_ready) begin
                    rd[src] = 1'b1;
                    if (last_beat) state_n = ACK;
                end
            end
            ACK: begin
                ack     = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                if (hold == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Burst source/length capture, beat countdown, hold-off timer and bad-grant flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            src       <= 2'd0;
            cnt       <= '0;
            hold      <= '0;
            err_grant <= 1'b0;
        end else begin
            err_grant <= (state == IDLE) && g_multi;
            case (state)
                IDLE: begin
                    if (state_n == XFER) begin
                        src <= g_idx;
                        cnt <= len[int'(g_idx)*LW +: LW];
                    end
                end
                XFER: begin
                    if (m_ready && !last_beat) cnt <= cnt - LW'(1);
                end
                ACK: begin
                    hold <= HW'(HOLDOFF - 1);
                end
                HOLD: begin
                    if (hold != '0) hold <= hold - HW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rr_grant_xfer.md
Name: rr_grant_xfer

Overview:
- Consumer stage directly downstream of the 4-way round-robin arbiter.
- Takes the arbiter's one-hot grant and qualifies it against the live request vector.
- Moves the winning requester's burst onto a shared valid/ready output bus.
- Returns a single-cycle ack to the arbiter so its token rotates. It also skips token slots whose owner has no pending request, and flags malformed grants.

Parameters:
DW, 8, data width per requester
LW, 4, burst-length field width; field value L means L+1 beats (1..2^LW)
HOLDOFF, 2, idle cycles after ack before grant is resampled (min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
req  in  4  request vector, the same vector that drives the arbiter
grant  in  4  one-hot grant from the arbiter
len  in  4*LW  per-requester burst length; slice i = len[i*LW +: LW]
data  in  4*DW  per-requester head-of-queue data; slice i = data[i*DW +: DW]
rd  out  4  per-requester pop strobe, one bit per accepted beat
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  DW  output beat data
m_src  out  2  index of the requester being served
m_last  out  1  final beat of the burst
ack  out  1  single-cycle transfer-done / skip pulse to the arbiter
busy  out  1  high in any state other than IDLE
err_grant  out  1  single-cycle pulse on a multi-hot qualified grant

Behaviour:
- Reset:
  - state=IDLE, src=0, cnt=0, hold counter=0.
  - rd, m_valid, m_data, m_src, m_last, ack, busy, err_grant all 0 in the cycle after the rst edge.
  - rst overrides every state, including mid-burst: no ack and no rd are issued for an aborted burst.
- State register encodes IDLE, XFER, ACK, HOLD. ack and m_valid decode from the registered state only.
- IDLE: compute g = grant & req.
  - req==0: stay in IDLE.
  - g one-hot: src <= index(g), cnt <= len[src]; next state XFER.
  - g==0 while req!=0: the token sits on an idle slot; next state ACK (skip). No bus activity.
  - g multi-hot: err_grant=1 for one cycle; stay in IDLE; no ack.
- XFER:
  - m_valid=1, m_src=src, m_data=data[src] (combinational mux on the registered src), m_last=(cnt==0).
  - Handshake when m_valid & m_ready: rd[src]=1 in the same cycle (combinational).
    - If not last: cnt decrements.
    - If last: next state ACK.
  - m_ready low: m_valid held, cnt held, rd=0. Data tracks data[src]; the requester holds its head stable until rd.
  - req[src] or grant changing mid-burst is ignored; the burst always completes.
  - Max burst is 2^LW beats (len all-ones). cnt never wraps below 0.
- ACK:
  - ack=1 for exactly one cycle; busy=1; next state HOLD with hold counter=HOLDOFF-1.
- HOLD:
  - Counts down. Return to IDLE after HOLDOFF cycles.
  - Purpose: covers the arbiter's registered-ack token rotation, so the grant is sampled only after the token has moved.
  - Also guarantees ack is low for at least HOLDOFF+1 cycles between pulses.
- Latency:
  - Grant qualified in IDLE cycle T, first m_valid in cycle T+1.
  - Last handshake in cycle T+k, ack in cycle T+k+1, grant resampled in cycle T+k+2+HOLDOFF.
  - Skip: ack in cycle T+1.
- busy=1 in XFER, ACK and HOLD.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 3 cycles with req=1111, grant=0001.
   - Required: all outputs 0 throughout, state IDLE; first transfer starts only after rst drops.
2. Single burst:
   - Stimulus: req=0010, grant=0010, len[1]=2, data[1]=8'hA5, m_ready=1.
   - Required: m_valid high 3 cycles with m_src=1, m_data=A5; rd=0010 each beat; m_last on beat 3; ack one cycle after beat 3; then 2 idle HOLD cycles.
   - Repeat with len[1]=4'hF: exactly 16 beats.
3. Backpressure:
   - Stimulus: same as scenario 2, m_ready pattern 1,0,0,1,0,1.
   - Required: rd pulses only on ready cycles; exactly 3 handshakes; m_valid and m_src stable while stalled; ack after the third handshake.
4. Skip:
   - Stimulus: req=1000, grant=0001.
   - Required: no m_valid, no rd; ack pulses in the cycle after sampling; HOLD lasts 2 cycles.
   - Then grant=1000: burst from src=3 starts.
5. Bad grant:
   - Stimulus: req=0110, grant=0110.
   - Required: err_grant=1 for one cycle; ack=0, m_valid=0, busy=0; block remains in IDLE.
6. Reset mid-burst:
   - Stimulus: len[2]=3; assert rst during the 2nd handshake cycle.
   - Required: m_valid=0 and rd=0 from the next cycle; no ack pulse; busy=0.
